// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write/counter bus of the multi-port register file
interface regfile_mp_if #(
    parameter int W   = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*W-1:0]  rd_data;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*W-1:0]    wr_data;
    logic              cnt_en;
    modport master (output rd_addr, wr_en, wr_addr, wr_data, cnt_en, input rd_data);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, cnt_en, output rd_data);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / 2-write register file with zero reg, reset-loaded SP and auto-increment counter; define REGFILE_BYPASS_EN for same-cycle write-to-read bypass
module regfile_mp #(
    parameter int           W       = 32,
    parameter int           DEPTH   = 32,
    parameter int           AW      = $clog2(DEPTH),
    parameter int           NRD     = 2,
    parameter int           SP_REG  = 2,
    parameter logic [W-1:0] SP_INIT = 32'h0000_03FC,
    parameter int           CNT_REG = 30
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave rf
);
    logic [W-1:0] regs_q [DEPTH];
    logic [W-1:0] regs_d [DEPTH];
    logic [W-1:0] rd_v   [NRD];

    // next state: counter increment first, then port 0, then port 1 so later writes win; reg 0 forced to zero
    always_comb begin
        for (int r = 0; r < DEPTH; r++) regs_d[r] = regs_q[r];
        if (rf.cnt_en) regs_d[CNT_REG] = regs_q[CNT_REG] + W'(1);
        for (int j = 0; j < 2; j++)
            if (rf.wr_en[j] && rf.wr_addr[j*AW +: AW] != '0) regs_d[rf.wr_addr[j*AW +: AW]] = rf.wr_data[j*W +: W];
        regs_d[0] = '0;
    end

    // storage with asynchronous reset to zero except the stack pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) regs_q[r] <= (r == SP_REG) ? SP_INIT : '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
        end
    end

    // combinational read; bypass (when built in) takes the newest enabled write, port 1 last, never during reset
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_v[i] = regs_q[rf.rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < 2; j++)
                if (rst_n && rf.wr_en[j] && rf.wr_addr[j*AW +: AW] != '0 && rf.wr_addr[j*AW +: AW] == rf.rd_addr[i*AW +: AW])
                    rd_v[i] = rf.wr_data[j*W +: W];
`else
`endif
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        assign rf.rd_data[g*W +: W] = rd_v[g];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench with a register-array model checked every negative edge
module tb_regfile_mp;
    localparam int W = 32, AW = 5, NRD = 4, SP = 2, CNT = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cmp_on = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] m [32];

    regfile_mp_if #(.W(W), .AW(AW), .NRD(NRD)) bus ();

    regfile_mp #(.W(W), .DEPTH(32), .NRD(NRD), .SP_REG(SP), .SP_INIT(32'h3FC), .CNT_REG(CNT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rf   (bus)
    );

    always #5 clk = ~clk;

    // architectural model: a plain array updated by the documented rules
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) m[r] <= (r == SP) ? 32'h3FC : 32'h0;
        end else begin
            if (bus.cnt_en) m[CNT] <= m[CNT] + 32'd1;
            if (bus.wr_en[0] && bus.wr_addr[4:0] != 0) m[bus.wr_addr[4:0]] <= bus.wr_data[31:0];
            if (bus.wr_en[1] && bus.wr_addr[9:5] != 0) m[bus.wr_addr[9:5]] <= bus.wr_data[63:32];
        end
    end

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = m[a];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && bus.wr_en[0] && bus.wr_addr[4:0] != 0 && bus.wr_addr[4:0] == a) v = bus.wr_data[31:0];
        if (rst_n && bus.wr_en[1] && bus.wr_addr[9:5] != 0 && bus.wr_addr[9:5] == a) v = bus.wr_data[63:32];
`endif
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // every-cycle comparison of all read ports against the model
    always @(negedge clk) begin
        if (cmp_on)
            for (int p = 0; p < NRD; p++)
                chk($sformatf("model_port%0d_addr%0d", p, bus.rd_addr[p*AW +: AW]), bus.rd_data[p*W +: W], exp_rd(bus.rd_addr[p*AW +: AW]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                      input logic [AW-1:0] a1, input logic [W-1:0] d1);
        bus.wr_en = en;
        bus.wr_addr = {a1, a0};
        bus.wr_data = {d1, d0};
    endtask

    function automatic logic [W-1:0] rd(input int p);
        return bus.rd_data[p*W +: W];
    endfunction

    initial begin
        bus.rd_addr = '0;
        bus.cnt_en = 1'b0;
        wr(2'b00, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a));
            #1 chk($sformatf("reset_read_%0d", a), rd(0), (a == SP) ? 32'h3FC : 32'h0);
        end
        cmp_on = 1'b1;
        tick();
        rst_n = 1'b1;
        bus.cnt_en = 1'b1;
        repeat (5) tick();
        bus.cnt_en = 1'b0;
        set_rd(0, CNT);
        #1 chk("cnt_after5", rd(0), 32'd5);

        wr(2'b11, 7, 32'hAAAA_0000, 7, 32'h5555_FFFF);
        tick();
        wr(2'b01, 0, 32'hFFFF_FFFF, 0, 0);
        set_rd(0, 7);
        #1 chk("port_conflict", rd(0), 32'h5555_FFFF);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        set_rd(0, 0);
        #1 chk("reg0_zero", rd(0), 32'h0);

        bus.cnt_en = 1'b1;
        wr(2'b01, CNT, 32'hFFFF_FFFE, 0, 0);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        set_rd(0, CNT);
        #1 chk("cnt_write_wins", rd(0), 32'hFFFF_FFFE);
        tick();
        #1 chk("cnt_ffffffff", rd(0), 32'hFFFF_FFFF);
        tick();
        #1 chk("cnt_wrap", rd(0), 32'h0);
        bus.cnt_en = 1'b0;

        wr(2'b01, 5, 32'h1234, 0, 0);
        set_rd(0, 5);
`ifdef REGFILE_BYPASS_EN
        #1 chk("bypass_same_cycle", rd(0), 32'h1234);
`else
        #1 chk("no_bypass_old", rd(0), 32'h0);
`endif
        tick();
        wr(2'b11, 6, 32'h1, 6, 32'h2);
        #1 chk("write_next_cycle", rd(0), 32'h1234);
        set_rd(0, 6);
`ifdef REGFILE_BYPASS_EN
        #1 chk("bypass_port1_wins", rd(0), 32'h2);
`else
        #1 chk("no_bypass_old6", rd(0), 32'h0);
`endif
        tick();
        wr(2'b01, 9, 32'hDEAD_BEEF, 0, 0);
        #1 chk("reg6_port1", rd(0), 32'h2);
        tick();
        wr(2'b00, 0, 0, 0, 0);
        set_rd(0, 0);
        set_rd(1, SP);
        set_rd(2, 9);
        set_rd(3, 9);
        #1;
        chk("mp_port0", rd(0), 32'h0);
        chk("mp_port1", rd(1), 32'h3FC);
        chk("mp_port2", rd(2), 32'hDEAD_BEEF);
        chk("mp_port3", rd(3), 32'hDEAD_BEEF);

        wr(2'b01, 9, 32'h1111, 0, 0);
        bus.cnt_en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_reg9", rd(2), 32'h0);
        chk("async_rst_sp", rd(1), 32'h3FC);
        tick();
        tick();
        chk("rst_held_reg9", rd(2), 32'h0);
        set_rd(0, CNT);
        #1 chk("rst_held_cnt", rd(0), 32'h0);
        wr(2'b00, 0, 0, 0, 0);
        bus.cnt_en = 1'b0;
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            wr(2'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom);
            bus.cnt_en = 1'($urandom);
            for (int p = 0; p < NRD; p++) set_rd(p, (i % 3 == 0) ? bus.wr_addr[(p%2)*AW +: AW] : 5'($urandom));
            tick();
        end
        wr(2'b00, 0, 0, 0, 0);
        tick();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
